// File: rtl/ball_motion_if.sv
// Control and status bundle between the frame logic and the ball motion engine.
// The master side drives the per-tick controls; the slave side is the ball engine.
interface ball_motion_if #(
    parameter int unsigned VW = 4
);
    logic          tick;
    logic [5:0]    width;
    logic [VW-1:0] speed_x;
    logic [VW-1:0] speed_y;
    logic          serve;
    logic          serve_dir;
    logic          pause;
    logic          hit_l;
    logic          hit_r;
    logic [9:0]    out_x;
    logic [8:0]    out_y;
    logic          dir_x;
    logic          dir_y;
    logic          bounce;
    logic          score_l;
    logic          score_r;
    logic [1:0]    state;

    modport master (
        output tick, width, speed_x, speed_y, serve, serve_dir, pause, hit_l, hit_r,
        input  out_x, out_y, dir_x, dir_y, bounce, score_l, score_r, state
    );

    modport slave (
        input  tick, width, speed_x, speed_y, serve, serve_dir, pause, hit_l, hit_r,
        output out_x, out_y, dir_x, dir_y, bounce, score_l, score_r, state
    );
endinterface

// File: rtl/ball_motion.sv
// Ball position engine: serves from screen centre, steps once per tick, reflects
// off the borders and paddles, and raises score pulses when x reflection is disabled.
module ball_motion #(
    parameter int unsigned SCR_W      = 640,
    parameter int unsigned SCR_H      = 480,
    parameter int unsigned MARGIN     = 10,
    parameter int unsigned VW         = 4,
    parameter int unsigned X_BOUNCE   = 1,
    parameter int unsigned HOLD_TICKS = 60
) (
    input  logic         clk,
    input  logic         reset_n,
    ball_motion_if.slave bus
);
    // One bit wider than the position outputs so pos + speed never wraps.
    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SCORED = 2'd2
    } state_t;

    state_t        state_q;
    logic [9:0]    pos_x;
    logic [8:0]    pos_y;
    logic          dir_x_q;
    logic          dir_y_q;
    logic          bounce_q;
    logic          score_l_q;
    logic          score_r_q;
    logic [HW-1:0] hold_cnt;

    logic [XW-1:0] cx, xmin, xmax, x_cur, x_up, sx, x_next;
    logic [YW-1:0] cy, ymin, ymax, y_cur, y_up, sy, y_next;
    logic          x_lo, y_lo;
    logic          x_dir_next, y_dir_next, x_refl, y_refl, x_to_l, x_to_r;

    assign sx    = XW'(bus.speed_x);
    assign sy    = YW'(bus.speed_y);
    assign cx    = XW'(SCR_W / 2) - XW'(bus.width >> 1);
    assign cy    = YW'(SCR_H / 2) - YW'(bus.width >> 1);
    assign xmin  = XW'(MARGIN);
    assign ymin  = YW'(MARGIN);
    assign xmax  = XW'(SCR_W - MARGIN) - XW'(bus.width);
    assign ymax  = YW'(SCR_H - MARGIN) - YW'(bus.width);
    assign x_cur = XW'(pos_x);
    assign y_cur = YW'(pos_y);
    assign x_up  = x_cur + sx;
    assign y_up  = y_cur + sy;
    assign x_lo  = x_cur < (xmin + sx);
    assign y_lo  = y_cur < (ymin + sy);

    // X axis step: paddle contact first, then the border / score limits.
    always_comb begin
        x_next     = x_cur;
        x_dir_next = dir_x_q;
        x_refl     = 1'b0;
        x_to_l     = 1'b0;
        x_to_r     = 1'b0;
        if (bus.hit_l && !dir_x_q) begin
            x_dir_next = 1'b1;
            x_refl     = 1'b1;
            x_next     = (x_up > xmax) ? xmax : x_up;
        end else if (bus.hit_r && dir_x_q) begin
            x_dir_next = 1'b0;
            x_refl     = 1'b1;
            x_next     = x_lo ? xmin : (x_cur - sx);
        end else if (dir_x_q) begin
            if (x_up > xmax) begin
                x_next = xmax;
                if (X_BOUNCE != 0) begin
                    x_dir_next = 1'b0;
                    x_refl     = 1'b1;
                end else begin
                    x_to_l = 1'b1;
                end
            end else begin
                x_next = x_up;
            end
        end else begin
            if (x_lo) begin
                x_next = xmin;
                if (X_BOUNCE != 0) begin
                    x_dir_next = 1'b1;
                    x_refl     = 1'b1;
                end else begin
                    x_to_r = 1'b1;
                end
            end else begin
                x_next = x_cur - sx;
            end
        end
    end

    // Y axis step: always reflects at the top and bottom borders.
    always_comb begin
        y_next     = y_cur;
        y_dir_next = dir_y_q;
        y_refl     = 1'b0;
        if (dir_y_q) begin
            if (y_up > ymax) begin
                y_next     = ymax;
                y_dir_next = 1'b0;
                y_refl     = 1'b1;
            end else begin
                y_next = y_up;
            end
        end else begin
            if (y_lo) begin
                y_next     = ymin;
                y_dir_next = 1'b1;
                y_refl     = 1'b1;
            end else begin
                y_next = y_cur - sy;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pos_x     <= 10'(cx);
            pos_y     <= 9'(cy);
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            bounce_q  <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            bounce_q  <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pos_x    <= 10'(cx);
                    pos_y    <= 9'(cy);
                    hold_cnt <= '0;
                    if (bus.serve) begin
                        state_q <= MOVE;
                        dir_x_q <= bus.serve_dir;
                        dir_y_q <= 1'b1;
                    end
                end
                MOVE: begin
                    if (bus.tick && !bus.pause) begin
                        pos_x     <= 10'(x_next);
                        pos_y     <= 9'(y_next);
                        dir_x_q   <= x_dir_next;
                        dir_y_q   <= y_dir_next;
                        bounce_q  <= x_refl | y_refl;
                        score_l_q <= x_to_l;
                        score_r_q <= x_to_r;
                        if (x_to_l || x_to_r) begin
                            state_q <= SCORED;
                        end
                    end
                end
                SCORED: begin
                    // Recentre on the transition so IDLE shows the centre immediately.
                    if (bus.tick) begin
                        if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
                            hold_cnt <= '0;
                            state_q  <= IDLE;
                            pos_x    <= 10'(cx);
                            pos_y    <= 9'(cy);
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_x   = pos_x;
    assign bus.out_y   = pos_y;
    assign bus.dir_x   = dir_x_q;
    assign bus.dir_y   = dir_y_q;
    assign bus.bounce  = bounce_q;
    assign bus.score_l = score_l_q;
    assign bus.score_r = score_r_q;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: default instance for motion/reflection, and a
// scoring instance (no x reflection, short hold) for the score path.
module tb_ball_motion;
    logic clk;
    logic reset_n;

    int n_vec;
    int n_err;

    ball_motion_if #(.VW(4)) bus_a ();
    ball_motion_if #(.VW(4)) bus_b ();

    ball_motion u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    ball_motion #(
        .X_BOUNCE   (0),
        .HOLD_TICKS (3)
    ) u_dut_s (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        bus_a.tick = 0; bus_a.width = 6'd10; bus_a.speed_x = 0; bus_a.speed_y = 0;
        bus_a.serve = 0; bus_a.serve_dir = 0; bus_a.pause = 0; bus_a.hit_l = 0; bus_a.hit_r = 0;
        bus_b.tick = 0; bus_b.width = 6'd10; bus_b.speed_x = 0; bus_b.speed_y = 0;
        bus_b.serve = 0; bus_b.serve_dir = 0; bus_b.pause = 0; bus_b.hit_l = 0; bus_b.hit_r = 0;
        steps(2);

        // Reset state with width 10
        check("rst_x", int'(bus_a.out_x), 315);
        check("rst_y", int'(bus_a.out_y), 235);
        check("rst_state", int'(bus_a.state), 0);
        check("rst_dirx", int'(bus_a.dir_x), 1);
        check("rst_diry", int'(bus_a.dir_y), 1);
        check("rst_bounce", int'(bus_a.bounce), 0);

        // Serve right, then one tick at speed 1/1
        reset_n = 1'b1;
        bus_a.serve = 1; bus_a.serve_dir = 1;
        step();
        bus_a.serve = 0;
        check("serve_state", int'(bus_a.state), 1);
        check("serve_x_notick", int'(bus_a.out_x), 315);
        bus_a.speed_x = 1; bus_a.speed_y = 1; bus_a.tick = 1;
        step();
        check("tick1_x", int'(bus_a.out_x), 316);
        check("tick1_y", int'(bus_a.out_y), 236);

        // Walk x to 618 (y frozen at speed 0), then reflect at XMAX=620
        bus_a.speed_x = 2; bus_a.speed_y = 0;
        step();
        bus_a.speed_x = 3;
        steps(100);
        check("walk_x", int'(bus_a.out_x), 618);
        check("walk_y_speed0", int'(bus_a.out_y), 236);
        step();
        check("xmax_x", int'(bus_a.out_x), 620);
        check("xmax_dirx", int'(bus_a.dir_x), 0);
        check("xmax_bounce", int'(bus_a.bounce), 1);
        bus_a.tick = 0;
        step();
        check("bounce_1cyc", int'(bus_a.bounce), 0);
        check("notick_hold_x", int'(bus_a.out_x), 620);
        bus_a.tick = 1;
        step();
        check("after_refl_x", int'(bus_a.out_x), 617);
        check("after_refl_bounce", int'(bus_a.bounce), 0);

        // Y up to YMAX=460 exactly, then a clamped reflection
        bus_a.speed_x = 0; bus_a.speed_y = 4;
        steps(56);
        check("ymax_reach", int'(bus_a.out_y), 460);
        check("ymax_reach_dir", int'(bus_a.dir_y), 1);
        check("ymax_reach_bounce", int'(bus_a.bounce), 0);
        step();
        check("ymax_refl_y", int'(bus_a.out_y), 460);
        check("ymax_refl_dir", int'(bus_a.dir_y), 0);
        check("ymax_refl_bounce", int'(bus_a.bounce), 1);
        steps(111);
        check("ydown_y", int'(bus_a.out_y), 16);
        check("x_speed0_hold", int'(bus_a.out_x), 617);
        check("x_speed0_dir", int'(bus_a.dir_x), 0);

        // Left paddle hit while moving left: reverse and step +3
        bus_a.hit_l = 1; bus_a.speed_x = 3;
        step();
        bus_a.hit_l = 0;
        check("hitl_x", int'(bus_a.out_x), 620);
        check("hitl_dir", int'(bus_a.dir_x), 1);
        check("hitl_bounce", int'(bus_a.bounce), 1);
        check("hitl_y", int'(bus_a.out_y), 12);

        // Simultaneous x and y reflections: one pulse
        step();
        check("dual_x", int'(bus_a.out_x), 620);
        check("dual_dirx", int'(bus_a.dir_x), 0);
        check("dual_y", int'(bus_a.out_y), 10);
        check("dual_diry", int'(bus_a.dir_y), 1);
        check("dual_bounce", int'(bus_a.bounce), 1);
        bus_a.tick = 0;
        step();
        check("dual_bounce_end", int'(bus_a.bounce), 0);

        // Right paddle flag agreeing with dir_x=0 is ignored
        bus_a.tick = 1; bus_a.hit_r = 1; bus_a.speed_y = 0;
        step();
        bus_a.hit_r = 0;
        check("hitr_ign_x", int'(bus_a.out_x), 617);
        check("hitr_ign_dir", int'(bus_a.dir_x), 0);
        check("hitr_ign_bounce", int'(bus_a.bounce), 0);

        // Pause freezes motion for 5 ticks
        bus_a.pause = 1; bus_a.speed_y = 4;
        steps(5);
        check("pause_x", int'(bus_a.out_x), 617);
        check("pause_y", int'(bus_a.out_y), 10);
        check("pause_bounce", int'(bus_a.bounce), 0);

        // Reset mid-MOVE with tick and serve asserted
        bus_a.pause = 0; bus_a.serve = 1;
        reset_n = 1'b0;
        step();
        bus_a.serve = 0; bus_a.tick = 0;
        check("rst2_state", int'(bus_a.state), 0);
        check("rst2_x", int'(bus_a.out_x), 315);
        check("rst2_y", int'(bus_a.out_y), 235);
        check("rst2_dirx", int'(bus_a.dir_x), 1);
        check("rst2_diry", int'(bus_a.dir_y), 1);
        reset_n = 1'b1;

        // Scoring instance: serve left, walk x to 12
        bus_b.serve = 1; bus_b.serve_dir = 0;
        step();
        bus_b.serve = 0;
        check("s_serve_state", int'(bus_b.state), 1);
        check("s_serve_dirx", int'(bus_b.dir_x), 0);
        bus_b.tick = 1; bus_b.speed_x = 3;
        steps(101);
        check("s_walk_x", int'(bus_b.out_x), 12);
        check("s_walk_state", int'(bus_b.state), 1);
        bus_b.speed_x = 4;
        step();
        check("s_score_x", int'(bus_b.out_x), 10);
        check("s_score_r", int'(bus_b.score_r), 1);
        check("s_score_l", int'(bus_b.score_l), 0);
        check("s_score_state", int'(bus_b.state), 2);
        check("s_score_dirx", int'(bus_b.dir_x), 0);
        check("s_score_bounce", int'(bus_b.bounce), 0);
        bus_b.tick = 0;
        step();
        check("s_score_pulse_end", int'(bus_b.score_r), 0);

        // Hold 3 ticks (pause ignored in SCORED), then recentre
        bus_b.tick = 1; bus_b.pause = 1;
        steps(2);
        check("s_hold_state", int'(bus_b.state), 2);
        check("s_hold_x", int'(bus_b.out_x), 10);
        step();
        bus_b.tick = 0; bus_b.pause = 0;
        check("s_idle_state", int'(bus_b.state), 0);
        check("s_idle_x", int'(bus_b.out_x), 315);
        check("s_idle_y", int'(bus_b.out_y), 235);

        // IDLE tracks width changes: width 20 -> 310/230
        bus_b.width = 6'd20;
        step();
        check("s_w20_x", int'(bus_b.out_x), 310);
        check("s_w20_y", int'(bus_b.out_y), 230);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 Parameters: SCR_W, default 640, screen width in pixels.
REQ-002 Parameters: SCR_H, default 480, screen height in pixels.
REQ-003 Parameters: MARGIN, default 10, border thickness in pixels on every edge.
REQ-004 Parameters: VW, default 4, width of the speed magnitude inputs.
REQ-005 Parameters: X_BOUNCE, default 1; 1 = reflect at left/right limits, 0 = left/right limits are score events.
REQ-006 Parameters: HOLD_TICKS, default 60, number of ticks held in SCORED before recentring.
REQ-007 Ports: clk  in  1  system clock; the block has one clock.
REQ-008 Ports: reset_n  in  1  reset, synchronous and active-low.
REQ-009 Ports: tick  in  1  one-cycle frame-step enable; all motion happens only on cycles with tick=1.
REQ-010 Ports: width  in  6  ball side length in pixels (0-63).
REQ-011 Ports: speed_x, speed_y  in  VW each  per-tick step magnitude on each axis.
REQ-012 Ports: serve  in  1  start request; serve_dir  in  1  initial x direction (1 = right).
REQ-013 Ports: pause  in  1  freezes motion while high.
REQ-014 Ports: hit_l, hit_r  in  1 each  paddle contact flags from the paddle logic.
REQ-015 Ports: out_x  out  10  ball upper-left X; out_y  out  9  ball upper-left Y.
REQ-016 Ports: dir_x, dir_y  out  1 each  current direction (1 = increasing coordinate).
REQ-017 Ports: bounce  out  1  one-cycle pulse on any reflection.
REQ-018 Ports: score_l, score_r  out  1 each  one-cycle pulse when the left/right player scores.
REQ-019 Ports: state  out  2  IDLE=0, MOVE=1, SCORED=2.

Function
REQ-020 Centre position: CX = SCR_W/2 - width/2, CY = SCR_H/2 - width/2, both computed with truncating integer division.
REQ-021 Limits: XMIN=YMIN=MARGIN, XMAX=SCR_W-MARGIN-width, YMAX=SCR_H-MARGIN-width.
REQ-022 IDLE: out_x=CX and out_y=CY, tracking width every cycle.
- serve=1 moves to MOVE on the next clock and loads dir_x=serve_dir, dir_y=1.
- serve does not require tick.
REQ-023 MOVE, when tick=1 and pause=0: each axis updates independently, exactly once per tick.
REQ-024 Step toward increasing coordinate: n = pos + speed.
- If n > MAX: pos <= MAX, direction flips, bounce=1.
- Otherwise pos <= n.
REQ-025 Step toward decreasing coordinate: if pos < MIN + speed, pos <= MIN, direction flips, bounce=1; otherwise pos <= pos - speed.
REQ-026 The ball never leaves [MIN, MAX] on either axis.
- Arithmetic is wide enough that n never wraps.
- There is no overshoot and no multi-tick reflection.
REQ-027 Paddles: hit_l=1 on a tick with dir_x=0 sets dir_x=1 and steps +speed_x that tick; hit_r mirrors this.
- A paddle hit takes priority over an x-limit event on the same tick and pulses bounce.
- A hit flag is ignored when it agrees with the current direction.
REQ-028 X_BOUNCE=0: reaching XMIN (per REQ-025) clamps pos, pulses score_r and enters SCORED; reaching XMAX pulses score_l and enters SCORED.
- No reflection occurs in either case.
REQ-029 SCORED: position frozen.
- The state counts HOLD_TICKS ticks (pause has no effect here).
- On the last counted tick it moves to IDLE on the next clock.
REQ-030 speed 0 on an axis: no movement and no reflection on that axis.
REQ-031 Simultaneous x and y reflections on one tick produce a single bounce pulse.
REQ-032 tick=0 or pause=1 in MOVE: all outputs hold and pulses stay 0.
REQ-033 Constraints: speed <= MARGIN and width < SCR_H-2*MARGIN; behaviour outside these limits is undefined.

Reset
REQ-034 reset_n=0 at a clock edge: state=IDLE, out_x=CX, out_y=CY, dir_x=1, dir_y=1, bounce=score_l=score_r=0, hold counter=0.
REQ-035 Reset has priority over tick, serve and hit inputs, including mid-MOVE and mid-SCORED.

Verification
REQ-036 Reset, defaults, width=10 -> out_x=315, out_y=235, state=0, dir_x=dir_y=1.
REQ-037 serve=1 with serve_dir=1, then tick with speed_x=speed_y=1 -> state=1, out_x=316, out_y=236.
REQ-038 out_x=618, dir_x=1, speed_x=3, width=10, tick -> out_x=620, dir_x=0, bounce pulse for 1 cycle; next tick -> out_x=617.
REQ-039 out_y=12, dir_y=0, speed_y=4, tick -> out_y=10, dir_y=1, bounce=1; with out_x at XMAX on the same tick -> still one bounce pulse.
REQ-040 X_BOUNCE=0, HOLD_TICKS=3, out_x=12, dir_x=0, speed_x=4, tick -> out_x=10, score_r pulse, state=2; after 3 ticks -> state=0, out_x=315.
REQ-041 In MOVE, pause=1 for 5 ticks -> position unchanged; then reset_n=0 mid-MOVE -> REQ-034 values on the next clock.
